// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and burst reader state encoding
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - 2-entry valid/ready buffer, head in entry 0
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DW = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [1:0]    occ
);

    logic [DW-1:0] ent0_q, ent0_d;
    logic [DW-1:0] ent1_q, ent1_d;
    logic [1:0]    occ_q, occ_d;
    logic [1:0]    slot;

    // Shift on pop, then write the push into the first free slot left after the pop
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        slot   = occ_q - {1'b0, pop};
        if (pop) begin
            ent0_d = ent1_q;
        end
        if (push) begin
            if (slot == 2'd0) begin
                ent0_d = push_data;
            end else begin
                ent1_d = push_data;
            end
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    // Buffer storage and occupancy; reset clears both so the stream reads back zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data = ent0_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pulls a programmed byte burst from the FIFO onto a byte stream
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] issue_left_q, issue_left_d;
    logic [LEN_W-1:0] xfer_left_q, xfer_left_d;
    logic             inflight_q, inflight_d;

    logic             pop;
    logic [1:0]       occ;
    logic [2:0]       pending;

    // Bytes already committed to the buffer once this cycle's pop is accounted for
    assign pop     = m_valid && m_ready;
    assign pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    // State, counter and in-flight registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            issue_left_q <= '0;
            xfer_left_q  <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_left_q <= issue_left_d;
            xfer_left_q  <= xfer_left_d;
            inflight_q   <= inflight_d;
        end
    end

    // Next state: a zero-length start goes straight to DONE without touching the FIFO
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (burst_len != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (pop && (xfer_left_q == LEN_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters load on an accepted start and count down reads issued / bytes transferred
    always_comb begin
        issue_left_d = issue_left_q;
        xfer_left_d  = xfer_left_q;
        inflight_d   = fifo_rd;
        if ((state_q == IDLE) && start) begin
            issue_left_d = burst_len;
            xfer_left_d  = burst_len;
        end else begin
            if (fifo_rd) begin
                issue_left_d = issue_left_q - LEN_W'(1);
            end
            if (pop && (xfer_left_q != '0)) begin
                xfer_left_d = xfer_left_q - LEN_W'(1);
            end
        end
    end

    // Outputs: a read is issued only when its returning byte is sure to find a free slot
    always_comb begin
        busy    = (state_q == READ);
        done    = (state_q == DONE);
        fifo_rd = (state_q == READ) && !fifo_empty && (issue_left_q != '0)
                  && (pending < 3'd2);
        m_valid = (occ != 2'd0);
        m_last  = m_valid && (xfer_left_q == LEN_W'(1));
    end

    fifo_skid_buf #(
        .DW(DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop),
        .head_data (m_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] burst_len;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    fifo_burst_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fq[$];
    logic [7:0] written[$];
    int rd_log[$];
    int pop_log[$];
    int rd_total = 0;
    int xf_total = 0;
    int cur_len = 0;
    int b_reads = 0;
    int b_xfers = 0;
    int done_cnt = 0;
    int feed_left = 0;
    int ready_mode = 0;
    int pat = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit exp_busy = 1'b0;
    bit exp_done_next = 1'b0;
    bit hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fq.push_back(b);
        written.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the FIFO model
    task automatic tick();
        bit rd;
        bit pop;
        bit exp_done;
        @(negedge clk);
        exp_done      = exp_done_next;
        exp_done_next = 1'b0;
        chk("done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(exp_busy));
        if (done) done_cnt++;
        if (hold_v) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(hold_d));
        end
        rd  = fifo_rd;
        pop = m_valid && m_ready;
        if (rd) begin
            chk("rd_not_empty", 32'(fifo_empty), 32'd0);
            chk("rd_within_len", 32'(b_reads < cur_len), 32'd1);
            chk("rd_room", 32'((b_reads - b_xfers - int'(pop)) < 2), 32'd1);
            b_reads++;
            rd_log.push_back(cyc - start_cyc);
        end
        if (m_valid) chk("last", 32'(m_last), 32'(b_xfers == cur_len - 1));
        if (pop) begin
            chk("data", 32'(m_data), (xf_total < written.size()) ? 32'(written[xf_total]) : 32'hdead);
            pop_log.push_back(cyc - start_cyc);
            xf_total++;
            b_xfers++;
            if (b_xfers == cur_len) begin
                exp_done_next = 1'b1;
                exp_busy      = 1'b0;
            end
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        if (start && !busy && !done) begin
            cur_len   = int'(burst_len);
            b_reads   = 0;
            b_xfers   = 0;
            start_cyc = cyc;
            rd_log.delete();
            pop_log.delete();
            if (burst_len == 8'd0) exp_done_next = 1'b1;
            else exp_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rd) begin
            fifo_data = fq.pop_front();
            rd_total++;
        end
        if (feed_left > 0 && fq.size() < 8 && $urandom_range(1, 0) == 1) begin
            push_byte(8'($urandom));
            feed_left--;
        end
        fifo_empty = (fq.size() == 0);
        start = 1'b0;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: begin m_ready = (pat % 3 == 0); pat++; end
            default: m_ready = 1'($urandom_range(1, 0));
        endcase
    endtask

    task automatic launch(input int len);
        start     = 1'b1;
        burst_len = 8'(len);
        tick();
    endtask

    task automatic run_until_done(input int budget);
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while (done_cnt == c0 && n < budget) begin
            tick();
            n++;
        end
        chk("timeout", 32'(done_cnt != c0), 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        burst_len  = 8'd0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        m_ready    = 1'b1;
        #1;
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Test 1: five preloaded bytes, consumer always ready
        for (int i = 0; i < 5; i++) push_byte(8'(8'h11 + i));
        ready_mode = 0;
        launch(5);
        run_until_done(40);
        chk("t1_reads", 32'(rd_log.size()), 32'd5);
        for (int i = 0; i < rd_log.size(); i++) chk("t1_rd_cycle", 32'(rd_log[i]), 32'(i + 1));
        chk("t1_xfers", 32'(pop_log.size()), 32'd5);
        if (pop_log.size() == 5) chk("t1_back_to_back", 32'(pop_log[4] - pop_log[0]), 32'd4);

        // Test 2: zero-length burst reads nothing and finishes at once
        tick();
        launch(0);
        tick();
        chk("t2_done_seen", 32'(done_cnt), 32'd2);
        chk("t2_no_reads", 32'(rd_log.size()), 32'd0);
        tick();

        // Test 3: FIFO runs dry mid-burst, then refills
        push_byte(8'h31);
        push_byte(8'h32);
        launch(4);
        repeat (12) tick();
        chk("t3_stall_busy", 32'(busy), 32'd1);
        chk("t3_stall_xfers", 32'(b_xfers), 32'd2);
        push_byte(8'h33);
        push_byte(8'h34);
        run_until_done(40);
        chk("t3_xfers", 32'(b_xfers), 32'd4);

        // Test 4: full FIFO with ready pattern 1,0,0 repeating
        for (int i = 0; i < 8; i++) push_byte(8'($urandom));
        ready_mode = 1;
        pat = 0;
        launch(8);
        run_until_done(100);
        chk("t4_xfers", 32'(b_xfers), 32'd8);
        chk("t4_reads", 32'(b_reads), 32'd8);

        // Test 5: reset in the middle of a 6-byte burst
        ready_mode = 0;
        tick();
        for (int i = 0; i < 6; i++) push_byte(8'($urandom));
        launch(6);
        for (int n = 0; n < 50 && b_xfers < 3; n++) tick();
        chk("t5_reached_3", 32'(b_xfers), 32'd3);
        rst = 1'b0;
        #1;
        chk("t5_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("t5_m_valid", 32'(m_valid), 32'd0);
        chk("t5_m_last", 32'(m_last), 32'd0);
        chk("t5_m_data", 32'(m_data), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        xf_total      = rd_total;
        exp_busy      = 1'b0;
        exp_done_next = 1'b0;
        hold_v        = 1'b0;
        cur_len       = 0;
        b_reads       = 0;
        b_xfers       = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        launch(fq.size());
        run_until_done(60);
        chk("t5_fifo_drained", 32'(fq.size()), 32'd0);

        // Test 6: a second start during the burst must be ignored
        tick();
        for (int i = 0; i < 6; i++) push_byte(8'($urandom));
        ready_mode = 2;
        launch(6);
        repeat (3) tick();
        start     = 1'b1;
        burst_len = 8'd2;
        tick();
        run_until_done(100);
        chk("t6_len_kept", 32'(b_xfers), 32'd6);

        // Random bursts: FIFO trickle-fed at random, consumer randomly stalls
        for (int k = 0; k < 4; k++) begin
            int len;
            len = $urandom_range(14, 1);
            tick();
            feed_left = len;
            launch(len);
            run_until_done(400);
            chk("rand_xfers", 32'(b_xfers), 32'(len));
            chk("rand_drained", 32'(fq.size()), 32'd0);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
